// File: rtl/wb_regfile_stage.sv
// Writeback stage: 2-entry skid buffer feeding a register file, with forwarding read ports.
// Optional build macro WB_ZERO_REG_EN hardwires register 0 to zero.
module wb_regfile_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic              in_we,
    input  logic              wb_stall,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              commit_valid,
    output logic [ADDR_W-1:0] commit_rd,
    output logic [DATA_W-1:0] commit_data
);

    localparam int NUM_REGS = 1 << ADDR_W;

    logic [DATA_W-1:0] buf_data [2];
    logic [ADDR_W-1:0] buf_rd   [2];
    logic              buf_we   [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        count;

    logic [DATA_W-1:0] regs [NUM_REGS];

    logic push;
    logic pop;
    logic head_write;
    logic head_fwd;
    logic tail_fwd;

    assign in_ready = !rst && (count != 2'd2);
    assign push     = in_valid && in_ready;
    assign pop      = (count != 2'd0) && !wb_stall;

`ifdef WB_ZERO_REG_EN
    assign head_write = buf_we[rd_ptr] && (buf_rd[rd_ptr] != '0);
`else
    assign head_write = buf_we[rd_ptr];
`endif

    // The tail (younger) entry only exists when both slots are occupied.
    assign head_fwd = (count != 2'd0) && buf_we[rd_ptr];
    assign tail_fwd = (count == 2'd2) && buf_we[~rd_ptr];

    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        rd_data_a = regs[rd_addr_a];
        if (head_fwd && buf_rd[rd_ptr] == rd_addr_a)
            rd_data_a = buf_data[rd_ptr];
        if (tail_fwd && buf_rd[~rd_ptr] == rd_addr_a)
            rd_data_a = buf_data[~rd_ptr];

        rd_data_b = regs[rd_addr_b];
        if (head_fwd && buf_rd[rd_ptr] == rd_addr_b)
            rd_data_b = buf_data[rd_ptr];
        if (tail_fwd && buf_rd[~rd_ptr] == rd_addr_b)
            rd_data_b = buf_data[~rd_ptr];

`ifdef WB_ZERO_REG_EN
        if (rd_addr_a == '0)
            rd_data_a = '0;
        if (rd_addr_b == '0)
            rd_data_b = '0;
`endif
    end

    // NOTE: buffer payload is left unreset since count gates its use; only the
    // register file is cleared because reads after reset must return zero.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_data[wr_ptr] <= in_data;
            buf_rd[wr_ptr]   <= in_rd;
            buf_we[wr_ptr]   <= in_we;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every read sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            count        <= 2'd0;
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            commit_valid <= 1'b0;
            commit_rd    <= '0;
            commit_data  <= '0;
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else begin
            commit_valid <= 1'b0;
            if (push)
                wr_ptr <= ~wr_ptr;
            if (pop) begin
                rd_ptr <= ~rd_ptr;
                if (head_write) begin
                    regs[buf_rd[rd_ptr]] <= buf_data[rd_ptr];
                    commit_valid         <= 1'b1;
                    commit_rd            <= buf_rd[rd_ptr];
                    commit_data          <= buf_data[rd_ptr];
                end
            end
            count <= count + 2'(push) - 2'(pop);
        end
    end

endmodule

// File: tb/tb_wb_regfile_stage.sv
// Bench for wb_regfile_stage: directed vector table, then random traffic against a queue model.
module tb_wb_regfile_stage;

`ifdef WB_ZERO_REG_EN
    localparam bit ZR = 1'b1;
`else
    localparam bit ZR = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [3:0]  in_rd;
    logic        in_we;
    logic        wb_stall;
    logic [3:0]  rd_addr_a;
    logic [31:0] rd_data_a;
    logic [3:0]  rd_addr_b;
    logic [31:0] rd_data_b;
    logic        commit_valid;
    logic [3:0]  commit_rd;
    logic [31:0] commit_data;

    wb_regfile_stage #(.DATA_W(32), .ADDR_W(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_rd(in_rd), .in_we(in_we), .wb_stall(wb_stall),
        .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a),
        .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b),
        .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_data(commit_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic [3:0] rd, input logic we,
                         input logic [31:0] d, input logic s, input logic [3:0] a,
                         input logic [3:0] b);
        @(negedge clk);
        rst = r; in_valid = v; in_rd = rd; in_we = we; in_data = d;
        wb_stall = s; rd_addr_a = a; rd_addr_b = b;
        #1;
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic        r, v;
        logic [3:0]  rd;
        logic        we;
        logic [31:0] d;
        logic        s;
        logic [3:0]  a, b;
        logic        chk_rd;
        logic        ready;
        logic [31:0] ea, eb;
        logic        cv;
        logic [3:0]  crd;
        logic [31:0] cd;
    } vec_t;

    function automatic vec_t mk(logic r, logic v, logic [3:0] rd, logic we, logic [31:0] d,
                                logic s, logic [3:0] a, logic [3:0] b, logic chk_rd,
                                logic ready, logic [31:0] ea, logic [31:0] eb, logic cv,
                                logic [3:0] crd, logic [31:0] cd);
        vec_t t;
        t.r = r; t.v = v; t.rd = rd; t.we = we; t.d = d; t.s = s; t.a = a; t.b = b;
        t.chk_rd = chk_rd; t.ready = ready; t.ea = ea; t.eb = eb;
        t.cv = cv; t.crd = crd; t.cd = cd;
        return t;
    endfunction

    vec_t tbl[22];

    // ---------------- reference model ----------------
    typedef struct {
        logic [3:0]  rd;
        logic        we;
        logic [31:0] data;
    } entry_t;

    entry_t      mq[$];
    logic [31:0] mregs[16];
    logic        m_cv;
    logic [3:0]  m_crd;
    logic [31:0] m_cd;

    function automatic logic [31:0] model_read(logic [3:0] addr);
        if (ZR && addr == 4'd0) return 32'd0;
        for (int i = mq.size() - 1; i >= 0; i--)
            if (mq[i].we && mq[i].rd == addr) return mq[i].data;
        return mregs[addr];
    endfunction

    function automatic logic model_ready();
        return !rst && (mq.size() < 2);
    endfunction

    task automatic model_reset();
        mq.delete();
        for (int i = 0; i < 16; i++) mregs[i] = 32'd0;
        m_cv = 1'b0; m_crd = 4'd0; m_cd = 32'd0;
    endtask

    task automatic model_edge();
        logic   do_push;
        entry_t e;
        if (rst) begin
            model_reset();
            return;
        end
        do_push = in_valid && model_ready();
        m_cv = 1'b0;
        if (mq.size() != 0 && !wb_stall) begin
            e = mq.pop_front();
            if (e.we && !(ZR && e.rd == 4'd0)) begin
                mregs[e.rd] = e.data;
                m_cv = 1'b1; m_crd = e.rd; m_cd = e.data;
            end
        end
        if (do_push) begin
            e.rd = in_rd; e.we = in_we; e.data = in_data;
            mq.push_back(e);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_rd = 4'd0; in_we = 1'b0; in_data = 32'd0;
        wb_stall = 1'b0; rd_addr_a = 4'd0; rd_addr_b = 4'd0;
        repeat (2) @(posedge clk);

        //            r  v  rd  we data          s  a  b  chk rdy ea            eb            cv crd cd
        tbl[0]  = mk(1, 1, 9,  1, 32'hAAAA,     0, 9, 0, 0,  0,  0,            0,            0, 0,  0);
        tbl[1]  = mk(0, 1, 3,  1, 32'hDEADBEEF, 0, 3, 9, 1,  1,  0,            0,            0, 0,  0);
        tbl[2]  = mk(0, 0, 0,  0, 0,            0, 3, 3, 1,  1,  32'hDEADBEEF, 32'hDEADBEEF, 0, 0,  0);
        tbl[3]  = mk(0, 0, 0,  0, 0,            0, 3, 0, 1,  1,  32'hDEADBEEF, 0,            1, 3,  32'hDEADBEEF);
        tbl[4]  = mk(0, 0, 0,  0, 0,            0, 3, 0, 1,  1,  32'hDEADBEEF, 0,            0, 0,  0);
        tbl[5]  = mk(0, 1, 5,  1, 1,            1, 5, 3, 1,  1,  0,            32'hDEADBEEF, 0, 0,  0);
        tbl[6]  = mk(0, 1, 5,  1, 2,            1, 5, 5, 1,  1,  1,            1,            0, 0,  0);
        tbl[7]  = mk(0, 1, 6,  1, 3,            1, 5, 6, 1,  0,  2,            0,            0, 0,  0);
        tbl[8]  = mk(0, 1, 6,  1, 3,            0, 5, 6, 1,  0,  2,            0,            0, 0,  0);
        tbl[9]  = mk(0, 1, 6,  1, 3,            0, 5, 6, 1,  1,  2,            0,            1, 5,  1);
        tbl[10] = mk(0, 1, 7,  0, 32'h77,       0, 5, 6, 1,  1,  2,            3,            1, 5,  2);
        tbl[11] = mk(0, 0, 0,  0, 0,            0, 7, 6, 1,  1,  0,            3,            1, 6,  3);
        tbl[12] = mk(0, 0, 0,  0, 0,            0, 7, 5, 1,  1,  0,            2,            0, 0,  0);
        tbl[13] = mk(0, 1, 0,  1, 5,            0, 0, 5, 1,  1,  0,            2,            0, 0,  0);
        tbl[14] = mk(0, 0, 0,  0, 0,            0, 0, 5, 1,  1,  ZR ? 0 : 5,   2,            0, 0,  0);
        tbl[15] = mk(0, 0, 0,  0, 0,            0, 0, 5, 1,  1,  ZR ? 0 : 5,   2,            !ZR, 0, 5);
        tbl[16] = mk(0, 0, 0,  0, 0,            0, 0, 5, 1,  1,  ZR ? 0 : 5,   2,            0, 0,  0);
        tbl[17] = mk(0, 1, 8,  1, 32'h88,       1, 8, 5, 1,  1,  0,            2,            0, 0,  0);
        tbl[18] = mk(0, 1, 9,  1, 32'h99,       1, 8, 9, 1,  1,  32'h88,       0,            0, 0,  0);
        tbl[19] = mk(1, 0, 0,  0, 0,            1, 8, 9, 0,  0,  0,            0,            0, 0,  0);
        tbl[20] = mk(0, 0, 0,  0, 0,            0, 8, 5, 1,  1,  0,            0,            0, 0,  0);
        tbl[21] = mk(0, 0, 0,  0, 0,            0, 3, 9, 1,  1,  0,            0,            0, 0,  0);

        for (int i = 0; i < 22; i++) begin
            drive(tbl[i].r, tbl[i].v, tbl[i].rd, tbl[i].we, tbl[i].d, tbl[i].s, tbl[i].a, tbl[i].b);
            check($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(tbl[i].ready));
            check($sformatf("vec%0d commit_valid", i), 32'(commit_valid), 32'(tbl[i].cv));
            if (tbl[i].cv) begin
                check($sformatf("vec%0d commit_rd", i), 32'(commit_rd), 32'(tbl[i].crd));
                check($sformatf("vec%0d commit_data", i), commit_data, tbl[i].cd);
            end
            if (tbl[i].chk_rd) begin
                check($sformatf("vec%0d rd_data_a", i), rd_data_a, tbl[i].ea);
                check($sformatf("vec%0d rd_data_b", i), rd_data_b, tbl[i].eb);
            end
            @(posedge clk);
        end

        // ---------------- random traffic against the model ----------------
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        model_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            drive($urandom_range(0, 99) < 2,
                  $urandom_range(0, 99) < 70,
                  4'($urandom_range(0, 7)),
                  $urandom_range(0, 99) < 80,
                  $urandom,
                  $urandom_range(0, 99) < 35,
                  4'($urandom_range(0, 7)),
                  4'($urandom_range(0, 15)));
            check($sformatf("rnd%0d in_ready", cyc), 32'(in_ready), 32'(model_ready()));
            check($sformatf("rnd%0d rd_data_a", cyc), rd_data_a,
                  rst ? rd_data_a : model_read(rd_addr_a));
            check($sformatf("rnd%0d rd_data_b", cyc), rd_data_b,
                  rst ? rd_data_b : model_read(rd_addr_b));
            check($sformatf("rnd%0d commit_valid", cyc), 32'(commit_valid), 32'(m_cv));
            if (m_cv) begin
                check($sformatf("rnd%0d commit_rd", cyc), 32'(commit_rd), 32'(m_crd));
                check($sformatf("rnd%0d commit_data", cyc), commit_data, m_cd);
            end
            @(posedge clk);
            model_edge();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
